// File: rtl/lamp_aspect_encoder.sv
// Flashing-lamp aspect transmitter: lit/unlit alternation per tick for go, steady unlit for stop.
// Outputs are registered (one clk from permit/feedback to lamp); no backpressure, the lamp driver always accepts.
module lamp_aspect_encoder #(
  parameter int TICK_DIV   = 4,
  parameter int HOLD_TICKS = 3,
  parameter int FB_DLY     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go_req,
  input  logic train_present,
  input  logic track_ok,
  input  logic lamp_fb,
  output logic lamp,
  output logic tick,
  output logic go_shown,
  output logic fault
);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_PRE   = 2'd1;
  localparam logic [1:0] ST_GO    = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  HOLD_MAX  = 8'(HOLD_TICKS);
  localparam logic [4:0]  FB_LIM    = 5'(FB_DLY);

  logic [1:0]  state;
  logic [1:0]  phase;
  logic [15:0] tick_cnt;
  logic [15:0] tick_cnt_nxt;
  logic [7:0]  hold_cnt;
  logic [4:0]  mm_cnt;
  logic        permit;
  logic        mismatch;
  logic        fb_trip;

  assign permit       = go_req & ~train_present & track_ok;
  assign mismatch     = lamp ^ lamp_fb;
  // Trips on the edge where the mismatch run would exceed FB_DLY cycles.
  assign fb_trip      = mismatch && (mm_cnt >= FB_LIM);
  assign tick_cnt_nxt = (tick_cnt == TICK_LAST) ? 16'd0 : tick_cnt + 16'd1;
  assign go_shown     = (state == ST_GO);
  assign fault        = (state == ST_FAULT);

  // tick is registered so it is glitch-free and drops immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= 16'd0;
      tick     <= 1'b0;
    end else begin
      tick_cnt <= tick_cnt_nxt;
      tick     <= (tick_cnt_nxt == TICK_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_cnt <= 5'd0;
    end else if (!mismatch) begin
      mm_cnt <= 5'd0;
    end else if (mm_cnt != 5'h1f) begin
      mm_cnt <= mm_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_STOP;
      phase    <= 2'd0;
      lamp     <= 1'b0;
      hold_cnt <= 8'd0;
    end else if (state == ST_FAULT) begin
      lamp <= 1'b0;
    end else if (fb_trip) begin
      state <= ST_FAULT;
      lamp  <= 1'b0;
    end else if (state != ST_STOP && !permit) begin
      // Forced stop is not aligned to a tick; the repeated unlit sample does the signalling.
      state    <= ST_STOP;
      lamp     <= 1'b0;
      hold_cnt <= 8'd0;
    end else if (tick) begin
      case (state)
        ST_STOP: begin
          if (hold_cnt == HOLD_MAX) begin
            if (permit) begin
              state <= ST_PRE;
              phase <= 2'd0;
              lamp  <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ST_PRE: begin
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            state <= ST_GO;
            lamp  <= 1'b1;
          end else begin
            lamp <= ~lamp;
          end
        end
        ST_GO: begin
          lamp <= ~lamp;
        end
        default: begin
          lamp <= 1'b0;
        end
      endcase
    end
  end

endmodule
